// File: rtl/operand_fetch_stage.sv
// Purpose: register file (X0..X30, X31 = XZR) plus operand select feeding the ID/EX latch that drives the ALU.
// Latency: 1 CLK from inputs to BusA/BusB/StoreData/ALUCtrl/DestOut/OutValid.
// Backpressure: Stall holds the latch (held operands still track writebacks); Flush kills it; writeback never blocks.
module operand_fetch_stage #(
    parameter int N = 64
) (
    input  logic         CLK,
    input  logic         Reset_L,
    input  logic [4:0]   RA,
    input  logic [4:0]   RB,
    input  logic         ALUSrc,
    input  logic [N-1:0] Imm,
    input  logic [3:0]   ALUCtrlIn,
    input  logic [4:0]   DestIn,
    input  logic         InValid,
    input  logic         Stall,
    input  logic         Flush,
    input  logic [4:0]   RW,
    input  logic [N-1:0] BusWr,
    input  logic         RegWr,
    output logic [N-1:0] BusA,
    output logic [N-1:0] BusB,
    output logic [N-1:0] StoreData,
    output logic [3:0]   ALUCtrl,
    output logic [4:0]   DestOut,
    output logic         OutValid
);

    localparam logic [4:0] XZR = 5'd31;

    // Entry 31 is never written, so it stays at its reset value of zero.
    logic [N-1:0] regFile [32];

    logic         wbEn;
    logic [N-1:0] rdA;
    logic [N-1:0] rdB;
    logic [N-1:0] opB;

    logic [4:0]   capRA;
    logic [4:0]   capRB;
    logic         capALUSrc;
    logic         refreshA;
    logic         refreshB;

    assign wbEn = RegWr && (RW != XZR);

    always_ff @(posedge CLK) begin
        if (!Reset_L) begin
            for (int i = 0; i < 32; i++) begin
                regFile[i] <= '0;
            end
        end else if (wbEn) begin
            regFile[RW] <= BusWr;
        end
    end

    // Read ports with write-through bypass so a same-cycle writeback is visible.
    always_comb begin
        rdA = regFile[RA];
        if (RA == XZR) begin
            rdA = '0;
        end else if (RegWr && (RW == RA)) begin
            rdA = BusWr;
        end
    end

    always_comb begin
        rdB = regFile[RB];
        if (RB == XZR) begin
            rdB = '0;
        end else if (RegWr && (RW == RB)) begin
            rdB = BusWr;
        end
    end

    assign opB = ALUSrc ? Imm : rdB;

    // After reset/flush the captured indices point at XZR, so a stall never refreshes a dead latch.
    assign refreshA = wbEn && (RW == capRA);
    assign refreshB = wbEn && (RW == capRB);

    always_ff @(posedge CLK) begin
        if (!Reset_L || Flush) begin
            BusA      <= '0;
            BusB      <= '0;
            StoreData <= '0;
            ALUCtrl   <= 4'b0000;
            DestOut   <= '0;
            OutValid  <= 1'b0;
            capRA     <= XZR;
            capRB     <= XZR;
            capALUSrc <= 1'b0;
        end else if (Stall) begin
            if (refreshA) begin
                BusA <= BusWr;
            end
            if (refreshB) begin
                StoreData <= BusWr;
                if (!capALUSrc) begin
                    BusB <= BusWr;
                end
            end
        end else begin
            BusA      <= rdA;
            BusB      <= opB;
            StoreData <= rdB;
            ALUCtrl   <= ALUCtrlIn;
            DestOut   <= DestIn;
            OutValid  <= InValid;
            capRA     <= RA;
            capRB     <= RB;
            capALUSrc <= ALUSrc;
        end
    end

endmodule
